// File: rtl/cmult_seq_8.sv
// Complex-multiply sequencer: takes (a+jb)*(c+jd), issues four magnitude products to a shared
// unsigned pipelined multiplier, re-applies signs on return and produces re=ac-bd, im=ad+bc.
module cmult_seq_8 #(
    parameter int unsigned DW    = 8,
    parameter int unsigned OUT_W = 2*DW+1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DW-1:0]           x_re,
    input  logic [DW-1:0]           x_im,
    input  logic [DW-1:0]           w_re,
    input  logic [DW-1:0]           w_im,
    output logic                    mul_en,
    output logic [DW-1:0]           mul_a,
    output logic [DW-1:0]           mul_b,
    input  logic [2*DW-1:0]         mul_result,
    input  logic                    mul_rdy,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] y_re,
    output logic signed [OUT_W-1:0] y_im
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t                  state, state_d;
    logic [DW-1:0]           a_r, b_r, c_r, d_r, a_d, b_d, c_d, d_d;
    logic [1:0]              issue_cnt, issue_cnt_d, collect_cnt, collect_cnt_d;
    logic [3:0]              sign_q, sign_d;
    logic signed [OUT_W-1:0] re_acc, re_acc_d, im_acc, im_acc_d, y_re_d, y_im_d;
    logic                    mul_en_d, in_ready_d, out_valid_d;
    logic [DW-1:0]           mul_a_d, mul_b_d;
    logic [DW-1:0]           sa, sb, sc, sd, op_a, op_b;
    logic [OUT_W-1:0]        ext;
    logic signed [OUT_W-1:0] prod;

    // |v| as unsigned; -128 maps to 128 without saturation
    function automatic logic [DW-1:0] mag(input logic [DW-1:0] v);
        return v[DW-1] ? DW'(-v) : v;
    endfunction

    // Next-state and datapath decode
    always_comb begin
        state_d       = state;
        a_d           = a_r;
        b_d           = b_r;
        c_d           = c_r;
        d_d           = d_r;
        issue_cnt_d   = issue_cnt;
        collect_cnt_d = collect_cnt;
        sign_d        = sign_q;
        re_acc_d      = re_acc;
        im_acc_d      = im_acc;
        y_re_d        = y_re;
        y_im_d        = y_im;
        mul_en_d      = 1'b0;
        mul_a_d       = '0;
        mul_b_d       = '0;
        sa            = a_r;
        sb            = b_r;
        sc            = c_r;
        sd            = d_r;

        // First pair issues straight from the inputs on the accept cycle
        if (state == IDLE) begin
            sa = x_re;
            sb = x_im;
            sc = w_re;
            sd = w_im;
        end
        // Pair order (a,c),(b,d),(a,d),(b,c)
        op_a = issue_cnt[0] ? sb : sa;
        op_b = (issue_cnt[0] ^ issue_cnt[1]) ? sd : sc;

        ext  = OUT_W'(mul_result);
        prod = sign_q[collect_cnt] ? $signed(-ext) : $signed(ext);

        if (state == IDLE && in_valid) begin
            a_d     = x_re;
            b_d     = x_im;
            c_d     = w_re;
            d_d     = w_im;
            state_d = ISSUE;
        end

        if ((state == IDLE && in_valid) || state == ISSUE) begin
            mul_en_d          = 1'b1;
            mul_a_d           = mag(op_a);
            mul_b_d           = mag(op_b);
            sign_d[issue_cnt] = op_a[DW-1] ^ op_b[DW-1];
            issue_cnt_d       = 2'(issue_cnt + 2'd1);
            if (state == ISSUE && issue_cnt == 2'd3)
                state_d = WAIT;
        end

        // Collection counts returned products, so it may overlap issue
        if ((state == ISSUE || state == WAIT) && mul_rdy) begin
            collect_cnt_d = 2'(collect_cnt + 2'd1);
            case (collect_cnt)
                2'd0: re_acc_d = prod;
                2'd1: re_acc_d = re_acc - prod;
                2'd2: im_acc_d = prod;
                default: begin
                    y_re_d  = re_acc;
                    y_im_d  = im_acc + prod;
                    state_d = DONE;
                end
            endcase
        end

        if (state == DONE && out_ready)
            state_d = IDLE;

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            a_r         <= '0;
            b_r         <= '0;
            c_r         <= '0;
            d_r         <= '0;
            issue_cnt   <= '0;
            collect_cnt <= '0;
            sign_q      <= '0;
            re_acc      <= '0;
            im_acc      <= '0;
            y_re        <= '0;
            y_im        <= '0;
            mul_en      <= 1'b0;
            mul_a       <= '0;
            mul_b       <= '0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
        end else begin
            state       <= state_d;
            a_r         <= a_d;
            b_r         <= b_d;
            c_r         <= c_d;
            d_r         <= d_d;
            issue_cnt   <= issue_cnt_d;
            collect_cnt <= collect_cnt_d;
            sign_q      <= sign_d;
            re_acc      <= re_acc_d;
            im_acc      <= im_acc_d;
            y_re        <= y_re_d;
            y_im        <= y_im_d;
            mul_en      <= mul_en_d;
            mul_a       <= mul_a_d;
            mul_b       <= mul_b_d;
            in_ready    <= in_ready_d;
            out_valid   <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_cmult_seq_8.sv
// Bench for cmult_seq_8 with a latency-8 multiplier model and an expected-result queue.
module tb_cmult_seq_8;

    localparam int unsigned DW      = 8;
    localparam int unsigned OUT_W   = 2*DW+1;
    localparam int unsigned MUL_LAT = 8;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in_valid, in_ready;
    logic [DW-1:0]           x_re, x_im, w_re, w_im;
    logic                    mul_en, mul_rdy;
    logic [DW-1:0]           mul_a, mul_b;
    logic [2*DW-1:0]         mul_result;
    logic                    out_valid, out_ready;
    logic signed [OUT_W-1:0] y_re, y_im;
    logic                    inj_rdy;

    typedef struct {
        int re;
        int im;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   lat, fa, fb;

    cmult_seq_8 dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .x_re(x_re), .x_im(x_im), .w_re(w_re), .w_im(w_im),
        .mul_en(mul_en), .mul_a(mul_a), .mul_b(mul_b),
        .mul_result(mul_result), .mul_rdy(mul_rdy),
        .out_valid(out_valid), .out_ready(out_ready),
        .y_re(y_re), .y_im(y_im)
    );

    always #5 clk = ~clk;

    // Multiplier model: en sampled at edge E, result visible after edge E+MUL_LAT
    logic [MUL_LAT:0]  rdy_pipe;
    logic [2*DW-1:0]   res_pipe [0:MUL_LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_pipe <= '0;
        end else begin
            rdy_pipe    <= {rdy_pipe[MUL_LAT-1:0], mul_en};
            res_pipe[0] <= 16'(mul_a) * 16'(mul_b);
            for (int i = 1; i <= MUL_LAT; i++)
                res_pipe[i] <= res_pipe[i-1];
        end
    end

    assign mul_rdy    = rdy_pipe[MUL_LAT] | inj_rdy;
    assign mul_result = inj_rdy ? 16'h7fff : res_pipe[MUL_LAT];

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One operation; holds out_ready low for 'stall' cycles after out_valid
    task automatic run_op(input int a, input int b, input int c, input int d, input int stall,
                          output int latency, output int first_a, output int first_b);
        int   cyc;
        exp_t e;
        cyc = 0;
        while (!in_ready && cyc < 50) begin
            @(posedge clk); #1; cyc++;
        end
        chk("in_ready_idle", longint'(in_ready), 1);
        @(negedge clk);
        x_re = 8'(a); x_im = 8'(b); w_re = 8'(c); w_im = 8'(d);
        in_valid = 1'b1;
        @(posedge clk);
        sb_q.push_back('{a*c - b*d, a*d + b*c});
        #1;
        first_a = int'(mul_a);
        first_b = int'(mul_b);
        chk("mul_en_first", longint'(mul_en), 1);
        chk("in_ready_busy", longint'(in_ready), 0);
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 0;
        do begin
            @(posedge clk); #1; cyc++;
        end while (!out_valid && cyc < 40);
        latency = cyc;
        chk("out_valid_rise", longint'(out_valid), 1);
        e = sb_q[0];
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            chk("hold_y_re", longint'(y_re), longint'(e.re));
            chk("hold_y_im", longint'(y_im), longint'(e.im));
            chk("hold_in_ready", longint'(in_ready), 0);
            chk("hold_out_valid", longint'(out_valid), 1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        e = sb_q.pop_front();
        chk("y_re", longint'(y_re), longint'(e.re));
        chk("y_im", longint'(y_im), longint'(e.im));
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("out_valid_drop", longint'(out_valid), 0);
        chk("in_ready_back", longint'(in_ready), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; inj_rdy = 1'b0;
        x_re = '0; x_im = '0; w_re = '0; w_im = '0;
        #1;
        chk("rst_in_ready", longint'(in_ready), 1);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_mul_en", longint'(mul_en), 0);
        chk("rst_y_re", longint'(y_re), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // (3+j4)*(2+j5) = -14 + j23, 13-cycle latency
        run_op(3, 4, 2, 5, 0, lat, fa, fb);
        chk("latency", longint'(lat), 13);
        chk("first_mul_a", longint'(fa), 3);
        chk("first_mul_b", longint'(fb), 2);

        // (-128)*(-128): magnitude 128 on both operands
        run_op(-128, 0, -128, 0, 0, lat, fa, fb);
        chk("neg128_mul_a", longint'(fa), 128);
        chk("neg128_mul_b", longint'(fb), 128);

        // Max-magnitude sign handling
        run_op(-128, 127, -128, -128, 0, lat, fa, fb);

        // Downstream stall of 5 cycles
        run_op(-7, 9, 11, -3, 5, lat, fa, fb);

        // Spurious product strobe while idle
        @(negedge clk);
        inj_rdy = 1'b1;
        @(posedge clk); #1;
        chk("spur_in_ready", longint'(in_ready), 1);
        chk("spur_out_valid", longint'(out_valid), 0);
        @(negedge clk);
        inj_rdy = 1'b0;
        run_op(1, 1, 1, -1, 0, lat, fa, fb);

        // Reset two cycles into issue
        @(negedge clk);
        x_re = 8'(5); x_im = 8'(-6); w_re = 8'(7); w_im = 8'(8);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", longint'(in_ready), 1);
        chk("mid_rst_mul_en", longint'(mul_en), 0);
        chk("mid_rst_mul_a", longint'(mul_a), 0);
        chk("mid_rst_mul_b", longint'(mul_b), 0);
        chk("mid_rst_out_valid", longint'(out_valid), 0);
        chk("mid_rst_y_im", longint'(y_im), 0);
        @(negedge clk);
        rst = 1'b0;
        run_op(2, 0, 3, 0, 0, lat, fa, fb);
        chk("post_rst_latency", longint'(lat), 13);

        // A couple of random operands
        for (int n = 0; n < 4; n++)
            run_op($signed(8'($urandom)), $signed(8'($urandom)),
                   $signed(8'($urandom)), $signed(8'($urandom)), n, lat, fa, fb);

        chk("sb_empty", longint'(sb_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
